// File: rtl/rom_fsm_sequencer_if.sv
// Table-configuration bus for rom_fsm_sequencer: write strobe, address {state, x},
// data {nextstate, out}, and the write-rejected pulse returned by the sequencer.
interface rom_fsm_sequencer_if #(
    parameter int SW = 3,
    parameter int OW = 3
);
    logic             cfg_we;
    logic [SW:0]      cfg_addr;
    logic [SW+OW-1:0] cfg_wdata;
    logic             cfg_err;

    modport master (output cfg_we, output cfg_addr, output cfg_wdata, input  cfg_err);
    modport slave  (input  cfg_we, input  cfg_addr, input  cfg_wdata, output cfg_err);
endinterface

// File: rtl/rom_fsm_sequencer.sv
// Run-control sequencer around a writable {nextstate, out} table addressed by {state, x_in}.
// Optional macro SEQ_VALID_CHECK_EN adds per-entry valid bits and an invalid-fetch fault (err).
module rom_fsm_sequencer #(
    parameter int SW = 3,
    parameter int OW = 3,
    parameter int CW = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    rom_fsm_sequencer_if.slave    cfg,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  step,
    input  logic                  x_in,
    input  logic [SW-1:0]         start_state,
    input  logic [SW-1:0]         halt_state,
    output logic [SW-1:0]         state,
    output logic [OW-1:0]         dout,
    output logic                  dout_valid,
    output logic [1:0]            ctl,
    output logic [CW-1:0]         adv_count,
    output logic                  err
);
    localparam int DEPTH = 2 ** (SW + 1);

    localparam logic [1:0] CTL_IDLE  = 2'b00;
    localparam logic [1:0] CTL_RUN   = 2'b01;
    localparam logic [1:0] CTL_PAUSE = 2'b10;
    localparam logic [1:0] CTL_DONE  = 2'b11;

    logic [SW+OW-1:0] tbl_r [DEPTH];
    logic [1:0]       ctl_r;
    logic [SW-1:0]    state_r;
    logic [OW-1:0]    dout_r;
    logic             dout_valid_r;
    logic [CW-1:0]    adv_count_r;
    logic             cfg_err_r;

    logic [SW:0]      fetch_addr_s;
    logic [SW+OW-1:0] entry_s;
    logic [SW-1:0]    nxt_state_s;
    logic [OW-1:0]    nxt_out_s;
    logic             wr_ok_s;
    logic             start_go_s;
    logic             adv_s;
    logic             fresh_s;
    logic [1:0]       ctl_nxt_s;

    assign fetch_addr_s = {state_r, x_in};
    assign entry_s      = tbl_r[fetch_addr_s];
    assign nxt_state_s  = entry_s[SW+OW-1:OW];
    assign nxt_out_s    = entry_s[OW-1:0];
    assign wr_ok_s      = cfg.cfg_we && (ctl_r != CTL_RUN);
    // stop outranks start everywhere; outside RUN it simply masks start
    assign start_go_s   = start && !stop;

`ifdef SEQ_VALID_CHECK_EN
    logic [DEPTH-1:0] vld_r;
    logic             fault_s;
    logic             err_r;
`endif

    // Table storage: not reset, so programmed contents survive a reset
    always_ff @(posedge clk) begin
        if (wr_ok_s) begin
            tbl_r[cfg.cfg_addr] <= cfg.cfg_wdata;
        end
    end

    // Controller next-state and advance/fresh-start decode
    always_comb begin
        ctl_nxt_s = ctl_r;
        adv_s     = 1'b0;
        fresh_s   = 1'b0;
        case (ctl_r)
            CTL_IDLE: begin
                if (start_go_s) begin
                    fresh_s   = 1'b1;
                    ctl_nxt_s = CTL_RUN;
                end else if (step) begin
                    adv_s     = 1'b1;
                    ctl_nxt_s = CTL_PAUSE;
                end else begin
                    ctl_nxt_s = CTL_IDLE;
                end
            end
            CTL_RUN: begin
                if (stop) begin
                    ctl_nxt_s = CTL_PAUSE;
                end else begin
                    adv_s     = 1'b1;
                    ctl_nxt_s = (nxt_state_s == halt_state) ? CTL_DONE : CTL_RUN;
                end
            end
            CTL_PAUSE: begin
                if (start_go_s) begin
                    ctl_nxt_s = CTL_RUN;
                end else if (step) begin
                    adv_s     = 1'b1;
                    ctl_nxt_s = (nxt_state_s == halt_state) ? CTL_DONE : CTL_PAUSE;
                end else begin
                    ctl_nxt_s = CTL_PAUSE;
                end
            end
            CTL_DONE: begin
                if (start_go_s) begin
                    fresh_s   = 1'b1;
                    ctl_nxt_s = CTL_RUN;
                end else begin
                    ctl_nxt_s = CTL_DONE;
                end
            end
            default: begin
                ctl_nxt_s = CTL_IDLE;
            end
        endcase
`ifdef SEQ_VALID_CHECK_EN
        fault_s = 1'b0;
        // An invalid fetch cancels the advance and ends the run
        if (adv_s && !vld_r[fetch_addr_s]) begin
            adv_s     = 1'b0;
            fault_s   = 1'b1;
            ctl_nxt_s = CTL_DONE;
        end else begin
            fault_s   = 1'b0;
        end
`endif
    end

    // Sequencer state, output and counter registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ctl_r        <= CTL_IDLE;
            state_r      <= {SW{1'b0}};
            dout_r       <= {OW{1'b0}};
            dout_valid_r <= 1'b0;
            adv_count_r  <= {CW{1'b0}};
            cfg_err_r    <= 1'b0;
        end else begin
            ctl_r        <= ctl_nxt_s;
            dout_valid_r <= adv_s;
            cfg_err_r    <= cfg.cfg_we && (ctl_r == CTL_RUN);
            if (fresh_s) begin
                state_r     <= start_state;
                adv_count_r <= {CW{1'b0}};
            end else if (adv_s) begin
                state_r     <= nxt_state_s;
                dout_r      <= nxt_out_s;
                if (adv_count_r != {CW{1'b1}}) begin
                    adv_count_r <= adv_count_r + {{(CW-1){1'b0}}, 1'b1};
                end
            end
        end
    end

`ifdef SEQ_VALID_CHECK_EN
    // Valid bits and sticky fault flag; cleared by reset, fault also by a fresh start
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld_r <= {DEPTH{1'b0}};
            err_r <= 1'b0;
        end else begin
            if (wr_ok_s) begin
                vld_r[cfg.cfg_addr] <= 1'b1;
            end
            if (fresh_s) begin
                err_r <= 1'b0;
            end else if (fault_s) begin
                err_r <= 1'b1;
            end
        end
    end
    assign err = err_r;
`else
    assign err = 1'b0;
`endif

    assign cfg.cfg_err = cfg_err_r;
    assign state       = state_r;
    assign dout        = dout_r;
    assign dout_valid  = dout_valid_r;
    assign ctl         = ctl_r;
    assign adv_count   = adv_count_r;

endmodule
